// File: rtl/mlp_sequencer.sv
// mlp_sequencer: time-multiplexed controller for one shared neuron datapath.
// It walks every hidden neuron over NUM_INPUTS inputs, then every output
// neuron over SIZE_HIDDEN hidden results, keeping a running signed argmax of
// the output-layer results. The label goes out on a valid/ready handshake.
//
// Optional build macro: MLP_SEQ_SCORE_EN adds the label_score output, which
// exposes the best-score register next to the label.
module mlp_sequencer #(
  parameter int N           = 16,
  parameter int NUM_INPUTS  = 62,
  parameter int SIZE_HIDDEN = 20,
  parameter int SIZE_OUTPUT = 10,
  parameter int CLOG2_IN    = 6,
  parameter int CLOG2_HID   = 5,
  parameter int CLOG2_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 layer_sel,
  output logic [CLOG2_HID-1:0] neuron_idx,
  output logic [CLOG2_IN-1:0]  x_idx,
  output logic                 mac_en,
  output logic                 mac_clr,
  output logic                 bias_en,
  output logic                 hid_we,
  input  logic [N-1:0]         res_data,
  output logic                 label_valid,
  input  logic                 label_ready,
`ifdef MLP_SEQ_SCORE_EN
  output logic [CLOG2_OUT-1:0] label,
  output logic [N-1:0]         label_score
`else
  output logic [CLOG2_OUT-1:0] label
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HID_MAC,
    S_HID_BIAS,
    S_HID_WB,
    S_OUT_MAC,
    S_OUT_BIAS,
    S_OUT_WB,
    S_DONE
  } state_e;

  // Last index of each loop, sized to the counter that walks it
  localparam logic [CLOG2_IN-1:0]  HID_X_LAST = CLOG2_IN'(NUM_INPUTS - 1);
  localparam logic [CLOG2_IN-1:0]  OUT_X_LAST = CLOG2_IN'(SIZE_HIDDEN - 1);
  localparam logic [CLOG2_HID-1:0] HID_N_LAST = CLOG2_HID'(SIZE_HIDDEN - 1);
  localparam logic [CLOG2_HID-1:0] OUT_N_LAST = CLOG2_HID'(SIZE_OUTPUT - 1);

  state_e                state_q, state_d;
  logic [CLOG2_HID-1:0]  nidx_q, nidx_d;
  logic [CLOG2_IN-1:0]   xidx_q, xidx_d;
  logic signed [N-1:0]   best_q, best_d;
  logic [CLOG2_OUT-1:0]  label_q, label_d;

  // Raw strobes decoded from state and x_idx; clk_en gating is applied at the ports
  logic mac_en_c, mac_clr_c, bias_en_c, hid_we_c;
  logic take_c;

  // Next-state, index/score update and strobe decode
  always_comb begin
    state_d   = state_q;
    nidx_d    = nidx_q;
    xidx_d    = xidx_q;
    best_d    = best_q;
    label_d   = label_q;
    mac_en_c  = 1'b0;
    mac_clr_c = 1'b0;
    bias_en_c = 1'b0;
    hid_we_c  = 1'b0;
    take_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // in_ready is clk_en here, and the register only loads when clk_en is high
        if (in_valid) begin
          state_d = S_HID_MAC;
          nidx_d  = '0;
          xidx_d  = '0;
        end
      end
      S_HID_MAC: begin
        mac_en_c  = 1'b1;
        mac_clr_c = (xidx_q == '0);
        if (xidx_q == HID_X_LAST) begin
          xidx_d  = '0;
          state_d = S_HID_BIAS;
        end else begin
          xidx_d = xidx_q + CLOG2_IN'(1);
        end
      end
      S_HID_BIAS: begin
        bias_en_c = 1'b1;
        state_d   = S_HID_WB;
      end
      S_HID_WB: begin
        hid_we_c = 1'b1;
        if (nidx_q == HID_N_LAST) begin
          nidx_d  = '0;
          state_d = S_OUT_MAC;
        end else begin
          nidx_d  = nidx_q + CLOG2_HID'(1);
          state_d = S_HID_MAC;
        end
      end
      S_OUT_MAC: begin
        mac_en_c  = 1'b1;
        mac_clr_c = (xidx_q == '0);
        if (xidx_q == OUT_X_LAST) begin
          xidx_d  = '0;
          state_d = S_OUT_BIAS;
        end else begin
          xidx_d = xidx_q + CLOG2_IN'(1);
        end
      end
      S_OUT_BIAS: begin
        bias_en_c = 1'b1;
        state_d   = S_OUT_WB;
      end
      S_OUT_WB: begin
        // Neuron 0 seeds the argmax; later ones must be strictly greater so ties keep the lower index
        take_c = (nidx_q == '0) || ($signed(res_data) > best_q);
        if (take_c) begin
          best_d  = $signed(res_data);
          label_d = CLOG2_OUT'(nidx_q);
        end
        if (nidx_q == OUT_N_LAST) begin
          nidx_d  = '0;
          state_d = S_DONE;
        end else begin
          nidx_d  = nidx_q + CLOG2_HID'(1);
          state_d = S_OUT_MAC;
        end
      end
      S_DONE: begin
        if (label_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, index and score registers; everything freezes while clk_en is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      nidx_q  <= '0;
      xidx_q  <= '0;
      best_q  <= '0;
      label_q <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      nidx_q  <= nidx_d;
      xidx_q  <= xidx_d;
      best_q  <= best_d;
      label_q <= label_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE) & clk_en;
  assign layer_sel   = (state_q == S_OUT_MAC) | (state_q == S_OUT_BIAS) | (state_q == S_OUT_WB);
  assign neuron_idx  = nidx_q;
  assign x_idx       = xidx_q;
  assign mac_en      = mac_en_c  & clk_en;
  assign mac_clr     = mac_clr_c & clk_en;
  assign bias_en     = bias_en_c & clk_en;
  assign hid_we      = hid_we_c  & clk_en;
  assign label_valid = (state_q == S_DONE);
  assign label       = label_q;
`ifdef MLP_SEQ_SCORE_EN
  assign label_score = best_q;
`endif

endmodule

// File: tb/tb_mlp_sequencer.sv
// Scoreboard bench for mlp_sequencer: three instances (default sizes,
// 4/3/2 and 4/3/5) share clock, reset and clk_en. Stimulus pushes the
// expected label/score/latency; a negedge monitor pops on each label handshake.
module tb_mlp_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en;
  bit   rnd_on = 1'b0;

  always #5 clk = ~clk;

  logic        iv [3];
  logic        ir [3];
  logic        ls [3];
  logic        me [3];
  logic        mc [3];
  logic        be [3];
  logic        we [3];
  logic        lv [3];
  logic        lr [3];
  logic [4:0]  nidx [3];
  logic [5:0]  xidx [3];
  logic [3:0]  lbl [3];
  logic [15:0] res [3];
`ifdef MLP_SEQ_SCORE_EN
  logic [15:0] lsc [3];
`endif
  logic signed [15:0] sc [3][20];

  // Datapath stand-in: output-layer result selected by neuron_idx
  always_comb begin
    for (int i = 0; i < 3; i++) res[i] = ls[i] ? sc[i][nidx[i]] : 16'h0007;
  end

  mlp_sequencer u_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(iv[0]), .in_ready(ir[0]),
    .layer_sel(ls[0]), .neuron_idx(nidx[0]), .x_idx(xidx[0]), .mac_en(me[0]),
    .mac_clr(mc[0]), .bias_en(be[0]), .hid_we(we[0]), .res_data(res[0]),
    .label_valid(lv[0]), .label_ready(lr[0]),
`ifdef MLP_SEQ_SCORE_EN
    .label_score(lsc[0]),
`endif
    .label(lbl[0]));

  mlp_sequencer #(.NUM_INPUTS(4), .SIZE_HIDDEN(3), .SIZE_OUTPUT(2)) u_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(iv[1]), .in_ready(ir[1]),
    .layer_sel(ls[1]), .neuron_idx(nidx[1]), .x_idx(xidx[1]), .mac_en(me[1]),
    .mac_clr(mc[1]), .bias_en(be[1]), .hid_we(we[1]), .res_data(res[1]),
    .label_valid(lv[1]), .label_ready(lr[1]),
`ifdef MLP_SEQ_SCORE_EN
    .label_score(lsc[1]),
`endif
    .label(lbl[1]));

  mlp_sequencer #(.NUM_INPUTS(4), .SIZE_HIDDEN(3), .SIZE_OUTPUT(5)) u_c (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(iv[2]), .in_ready(ir[2]),
    .layer_sel(ls[2]), .neuron_idx(nidx[2]), .x_idx(xidx[2]), .mac_en(me[2]),
    .mac_clr(mc[2]), .bias_en(be[2]), .hid_we(we[2]), .res_data(res[2]),
    .label_valid(lv[2]), .label_ready(lr[2]),
`ifdef MLP_SEQ_SCORE_EN
    .label_score(lsc[2]),
`endif
    .label(lbl[2]));

  typedef struct {
    int id;
    int lbl;
    int score;
    int lat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  int          en_e [3];
  int          lat [3];
  bit          busy [3];
  bit          seen [3];
  int          cnt_en = 0, cnt_clr = 0, cnt_we = 0, viol = 0;
  logic [27:0] pat = '0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin busy[i] = 1'b0; seen[i] = 1'b0; end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!clk_en && (me[i] | mc[i] | be[i] | we[i] | ir[i])) viol++;
        if (busy[i] && !seen[i] && lv[i]) begin seen[i] = 1'b1; lat[i] = en_e[i]; end
        if (i == 0 && clk_en) begin
          cnt_en  += int'(me[0]);
          cnt_clr += int'(mc[0]);
          cnt_we  += int'(we[0]);
        end
        if (i == 1 && busy[1] && clk_en && en_e[1] >= 0 && en_e[1] < 28) pat[en_e[1]] = me[1];
        if (lv[i] && lr[i] && clk_en) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_label dut=%0d label=%0d", i, lbl[i]);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("label_dut", i, e.id);
            chk("label", int'(lbl[i]), e.lbl);
            chk("latency", lat[i], e.lat);
`ifdef MLP_SEQ_SCORE_EN
            chk("label_score", int'($signed(lsc[i])), e.score);
`endif
          end
          busy[i] = 1'b0;
        end
        if (iv[i] && ir[i] && clk_en) begin
          busy[i] = 1'b1; seen[i] = 1'b0; en_e[i] = -1; lat[i] = -1;
        end
        if (clk_en) en_e[i]++;
      end
    end
  end

  // clk_en driver: constant high, or a coin toss per cycle when rnd_on
  initial begin
    clk_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      clk_en = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Present one sample for one cycle; optionally push its expected result
  task automatic run(input int d, input bit push, input int el, input int es, input int elat);
    if (push) q.push_back('{d, el, es, elat});
    @(posedge clk); #1;
    iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    chk("in_ready_drop", int'(ir[d]), 0);
  endtask

  task automatic wait_empty(input int maxc);
    for (int c = 0; c < maxc; c++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  int          s_en, s_clr, s_we, hold_bad;
  logic [3:0]  cap;
  logic [27:0] exp_pat;
  bit          got;

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; lr[i] = 1'b1;
      for (int k = 0; k < 20; k++) sc[i][k] = 16'sd0;
    end
    // Reset values while held in reset
    #12;
    chk("rst_in_ready", int'(ir[0]), 1);
    chk("rst_label_valid", int'(lv[0]), 0);
    chk("rst_label", int'(lbl[0]), 0);
    chk("rst_neuron_idx", int'(nidx[0]), 0);
    chk("rst_x_idx", int'(xidx[0]), 0);
    chk("rst_mac_en", int'(me[0]), 0);
    #1 rst = 1'b1;

    // Default sizes: argmax with a duplicate maximum at 3 and 5
    sc[0][0] = 16'sd3;  sc[0][1] = -16'sd1; sc[0][2] = 16'sd7;  sc[0][3] = 16'sd100;
    sc[0][4] = -16'sd50; sc[0][5] = 16'sd100; sc[0][6] = 16'sd0; sc[0][7] = 16'sd2;
    sc[0][8] = 16'sd99; sc[0][9] = -16'sd100;
    s_en = cnt_en; s_clr = cnt_clr; s_we = cnt_we;
    run(0, 1'b1, 3, 100, 1500);
    wait_empty(1600);
    chk("hid_we_pulses", cnt_we - s_we, 20);
    chk("mac_clr_pulses", cnt_clr - s_clr, 30);
    chk("mac_en_cycles", cnt_en - s_en, 1440);

    // 4/3/2: mac_en pattern and 28-cycle latency
    exp_pat = '0;
    for (int h = 0; h < 3; h++) for (int k = 0; k < 4; k++) exp_pat[h * 6 + k] = 1'b1;
    for (int o = 0; o < 2; o++) for (int k = 0; k < 3; k++) exp_pat[18 + o * 5 + k] = 1'b1;
    sc[1][0] = 16'sd1; sc[1][1] = 16'sd4;
    run(1, 1'b1, 1, 4, 28);
    wait_empty(100);
    chk("mac_en_pattern", int'(pat), int'(exp_pat));

    // 4/3/5: tie keeps lowest index
    sc[2][0] = 16'sd5; sc[2][1] = -16'sd3; sc[2][2] = 16'sd9; sc[2][3] = 16'sd9; sc[2][4] = 16'sd2;
    run(2, 1'b1, 2, 9, 43);
    wait_empty(100);

    // 4/3/5: all most-negative, then hold in DONE with label_ready low
    for (int k = 0; k < 5; k++) sc[2][k] = 16'sh8000;
    lr[2] = 1'b0;
    run(2, 1'b1, 0, -32768, 43);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = lv[2];
    end
    chk("done_reached", int'(got), 1);
    cap = lbl[2];
    @(posedge clk); #1;
    iv[2] = 1'b1;
    hold_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!lv[2] || lbl[2] != cap || ir[2]) hold_bad++;
    end
    chk("done_hold", hold_bad, 0);
    @(posedge clk); #1;
    lr[2] = 1'b1; iv[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_in_ready", int'(ir[2]), 1);
    wait_empty(5);

    // Default sizes with clk_en randomly toggled
    sc[0][0] = -16'sd5; sc[0][1] = -16'sd4; sc[0][2] = -16'sd3; sc[0][3] = -16'sd2;
    sc[0][4] = -16'sd1; sc[0][5] = -16'sd2; sc[0][6] = -16'sd3; sc[0][7] = -16'sd4;
    sc[0][8] = -16'sd5; sc[0][9] = -16'sd6;
    viol = 0;
    run(0, 1'b1, 4, -1, 1500);
    rnd_on = 1'b1;
    wait_empty(8000);
    rnd_on = 1'b0;
    chk("strobes_gated", viol, 0);

    // Asynchronous reset in the output layer after a partial label exists
    run(0, 1'b0, 0, 0, 0);
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      got = ls[0] && (nidx[0] == 5'd3);
    end
    chk("reached_out_layer", int'(got), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(ir[0]), 1);
    chk("mid_rst_label", int'(lbl[0]), 0);
    chk("mid_rst_layer_sel", int'(ls[0]), 0);
    chk("mid_rst_neuron_idx", int'(nidx[0]), 0);
    chk("mid_rst_x_idx", int'(xidx[0]), 0);
    chk("mid_rst_mac_en", int'(me[0]), 0);
    chk("mid_rst_label_valid", int'(lv[0]), 0);
    #3 rst = 1'b1;

    // A fresh sample after reset completes normally
    run(0, 1'b1, 4, -1, 1500);
    wait_empty(1600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
